// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the three-requester memory arbiter.
//   NUM_REQ        number of requesters
//   REQ_FETCH/DATA/DMA  requester indices (bit positions in req/gnt/done)
//   state_t        arbiter FSM state
//   req_idx_t      requester index / round-robin pointer type
//   rr_next()      pointer successor, wrapping DMA back to FETCH
//   one_hot()      index to per-requester one-hot vector
package mem_arbiter_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DMA   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t rr_next(input req_idx_t k);
        return (k == req_idx_t'(REQ_DMA)) ? req_idx_t'(REQ_FETCH) : k + 2'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input req_idx_t k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   req/we/addr/wdata  per-requester request, requester k in slice k
//   gnt/done           one-cycle grant and completion pulses
//   rdata/busy         read data and ownership flag
//   mem_*              memory port
// Modports: slave = the arbiter; master = the environment that drives
// requests and models the memory (so it also drives mem_rdata).
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin winner selection.
//   req    per-requester request vector
//   ptr    requester with highest priority this round
//   valid  any request present
//   index  winning requester: first set bit scanning ptr, ptr+1, ptr+2 (mod 3)
module rr_picker
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic               valid,
    output req_idx_t           index
);

    req_idx_t cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of three requesters (fetch, data, DMA)
// access to a single fixed-latency memory port.
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   bus        mem_arbiter_if.slave: requests in, grant/done/rdata/busy out,
//              memory enable/strobe/address/data out, memory read data in
// Parameters: ADDR_W, DATA_W (must match the interface instance),
//             MEM_LAT memory latency in cycles, 1..4.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
)(
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t             state;
    req_idx_t           ptr;
    req_idx_t           owner;
    logic [1:0]         lat_cnt;

    logic               pick_valid;
    req_idx_t           pick_index;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               busy_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    rr_picker u_rr_picker (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    // The winner's we/addr/wdata are latched straight into the memory-port
    // registers, which stay stable for the whole BUSY period and then hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            lat_cnt     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= '0;
                    if (pick_valid) begin
                        state       <= BUSY;
                        owner       <= pick_index;
                        ptr         <= rr_next(pick_index);
                        lat_cnt     <= 2'(MEM_LAT - 1);
                        gnt_q       <= one_hot(pick_index);
                        busy_q      <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.we[pick_index];
                        mem_addr_q  <= bus.addr[pick_index*ADDR_W +: ADDR_W];
                        mem_wdata_q <= bus.wdata[pick_index*DATA_W +: DATA_W];
                    end else begin
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end
                end
                BUSY: begin
                    gnt_q <= '0;
                    if (lat_cnt == 2'd0) begin
                        // Done cycle is IDLE, so the next arbitration overlaps it.
                        state    <= IDLE;
                        done_q   <= one_hot(owner);
                        busy_q   <= 1'b0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LAT = 2, 8-bit address/data).
// A transaction-level reference model tracks the cycle number of the
// current grant and derives every output from it; directed table vectors,
// hand-written corner sequences and a random phase all run against it.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (L)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: transfer granted at cycle m_gcyc owns the memory in
    // cycles m_gcyc .. m_gcyc+L-1 and completes at m_gcyc+L.
    int          m_gcyc  = -1000;
    int          m_owner = 0;
    int          m_ptr   = 0;
    logic        m_we    = 1'b0;
    logic [7:0]  m_addr  = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rdata = '0;
    logic        m_clear = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Applies the inputs of the current cycle to the model (before the edge).
    task automatic model_step();
        bit found;
        if (reset) begin
            m_ptr   = 0;
            m_gcyc  = -1000;
            m_rdata = '0;
            m_clear = 1'b1;
        end else begin
            if (cyc + 1 == m_gcyc + L && !m_we)
                m_rdata = bus.mem_rdata;
            if (cyc >= m_gcyc + L) begin
                found = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    int k;
                    k = (m_ptr + i) % 3;
                    if (!found && bus.req[k]) begin
                        found   = 1'b1;
                        m_owner = k;
                        m_gcyc  = cyc + 1;
                        m_we    = bus.we[k];
                        m_addr  = bus.addr[k*AW +: AW];
                        m_wdata = bus.wdata[k*DW +: DW];
                        m_ptr   = (k + 1) % 3;
                        m_clear = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic [2:0] e_gnt;
        logic [2:0] e_done;
        logic       owned;
        owned  = (cyc >= m_gcyc) && (cyc < m_gcyc + L);
        e_gnt  = '0;
        e_done = '0;
        if (cyc == m_gcyc)     e_gnt[m_owner]  = 1'b1;
        if (cyc == m_gcyc + L) e_done[m_owner] = 1'b1;
        chk("m_gnt",    bus.gnt,    e_gnt);
        chk("m_done",   bus.done,   e_done);
        chk("m_busy",   bus.busy,   owned);
        chk("m_mem_en", bus.mem_en, owned);
        chk("m_mem_we", bus.mem_we, owned && m_we);
        chk("m_rdata",  bus.rdata,  m_rdata);
        if (owned) begin
            chk("m_mem_addr",  bus.mem_addr,  m_addr);
            chk("m_mem_wdata", bus.mem_wdata, m_wdata);
        end else if (m_clear) begin
            chk("m_rst_addr",  bus.mem_addr,  0);
            chk("m_rst_wdata", bus.mem_wdata, 0);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req       = '0;
        bus.we        = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [23:0] addr;
        logic [23:0] wdata;
        logic [7:0]  mrd;
        logic [2:0]  exp_gnt;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Each vector starts from IDLE; pointer sequence from reset: 0,1,2,0,1,0,2,1.
        vecs[0] = '{3'b001, 3'b000, 24'h00_00_10, 24'h00_00_00, 8'hA5, 3'b001, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{3'b010, 3'b010, 24'h00_20_00, 24'h00_3C_00, 8'h11, 3'b010, 1'b1, 8'h20, 8'h3C, 8'hA5};
        vecs[2] = '{3'b111, 3'b000, 24'h03_02_01, 24'h00_00_00, 8'h77, 3'b100, 1'b0, 8'h03, 8'h00, 8'h77};
        vecs[3] = '{3'b011, 3'b000, 24'h00_41_40, 24'h00_00_00, 8'h5A, 3'b001, 1'b0, 8'h40, 8'h00, 8'h5A};
        vecs[4] = '{3'b101, 3'b100, 24'h52_00_50, 24'hEE_00_00, 8'h33, 3'b100, 1'b1, 8'h52, 8'hEE, 8'h5A};
        vecs[5] = '{3'b110, 3'b000, 24'h62_61_00, 24'h00_00_00, 8'h99, 3'b010, 1'b0, 8'h61, 8'h00, 8'h99};
        vecs[6] = '{3'b001, 3'b001, 24'h00_00_70, 24'h00_00_12, 8'h44, 3'b001, 1'b1, 8'h70, 8'h12, 8'h99};

        do_reset();
        chk("rst_gnt",   bus.gnt,   0);
        chk("rst_done",  bus.done,  0);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_rdata", bus.rdata, 0);

        // Directed vectors, one isolated transfer each.
        for (int v = 0; v < 7; v++) begin
            bus.req       = vecs[v].req;
            bus.we        = vecs[v].we;
            bus.addr      = vecs[v].addr;
            bus.wdata     = vecs[v].wdata;
            bus.mem_rdata = vecs[v].mrd;
            tick();
            chk("vec_gnt",       bus.gnt,       vecs[v].exp_gnt);
            chk("vec_mem_en",    bus.mem_en,    1);
            chk("vec_mem_we",    bus.mem_we,    vecs[v].exp_we);
            chk("vec_mem_addr",  bus.mem_addr,  vecs[v].exp_addr);
            chk("vec_mem_wdata", bus.mem_wdata, vecs[v].exp_wdata);
            bus.req = '0;
            for (int b = 1; b < L; b++) begin
                tick();
                chk("vec_hold_gnt",  bus.gnt,      0);
                chk("vec_hold_en",   bus.mem_en,   1);
                chk("vec_hold_addr", bus.mem_addr, vecs[v].exp_addr);
                chk("vec_hold_done", bus.done,     0);
            end
            tick();
            chk("vec_done",   bus.done,   vecs[v].exp_gnt);
            chk("vec_rdata",  bus.rdata,  vecs[v].exp_rdata);
            chk("vec_end_en", bus.mem_en, 0);
            chk("vec_end_bs", bus.busy,   0);
        end

        // All three requesting continuously, each dropping on its grant.
        do_reset();
        bus.req  = 3'b111;
        bus.addr = 24'h33_22_11;
        for (int c = 1; c <= 9; c++) begin
            logic [2:0] e;
            tick();
            e = (c == 1) ? 3'b001 : (c == 4) ? 3'b010 : (c == 7) ? 3'b100 : 3'b000;
            chk("rr_gnt", bus.gnt, e);
            bus.req = bus.req & ~bus.gnt;
        end
        // Pointer wrapped to 0: requester 0 beats requester 1.
        bus.req = 3'b011;
        tick();
        chk("wrap_gnt", bus.gnt, 3'b001);
        bus.req = '0;
        for (int c = 0; c < L; c++) tick();

        // Reset in the last BUSY cycle of a fetch aborts it.
        do_reset();
        bus.req  = 3'b001;
        bus.we   = '0;
        bus.addr = 24'h00_00_10;
        tick();
        chk("abort_gnt", bus.gnt, 3'b001);
        bus.req = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("abort_mem_en", bus.mem_en, 0);
        chk("abort_done",   bus.done,   0);
        chk("abort_busy",   bus.busy,   0);
        reset    = 1'b0;
        bus.req  = 3'b100;
        bus.addr = 24'h33_00_00;
        tick();
        chk("after_abort_gnt",  bus.gnt,      3'b100);
        chk("after_abort_addr", bus.mem_addr, 8'h33);
        bus.req = '0;
        for (int c = 0; c < L; c++) tick();
        chk("after_abort_done", bus.done, 3'b100);

        // req[2] pulsed only while BUSY is never seen.
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        tick();
        bus.req = 3'b100;
        tick();
        bus.req = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("pulse_no_gnt2",  bus.gnt[2],  0);
            chk("pulse_no_done2", bus.done[2], 0);
        end

        // Random legal traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (bus.gnt[k]) begin
                    bus.req[k] = 1'b0;
                end else if (bus.req[k]) begin
                    if ($urandom_range(15) == 0) bus.req[k] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    bus.req[k]              = 1'b1;
                    bus.we[k]               = 1'($urandom_range(1));
                    bus.addr[k*AW +: AW]    = 8'($urandom);
                    bus.wdata[k*DW +: DW]   = 8'($urandom);
                end
            end
            bus.mem_rdata = 8'($urandom);
            reset         = ($urandom_range(149) == 0);
            tick();
        end
        reset   = 1'b0;
        bus.req = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
